// File: rtl/exe_div_pkg.sv
// Shared encodings for the EXE-stage RV32M divide unit: instruction fields,
// FSM states and the divide-instruction decoder.
package exe_div_pkg;

    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    // Fill bit for the divide-by-zero quotient; replicated to the datapath width.
    localparam logic DIV_ALL_ONES = 1'b1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic is_div;
        logic is_signed;
        logic is_rem;
    } div_dec_t;

    function automatic div_dec_t decode_div(input logic [6:0] opcode,
                                            input logic [2:0] funct3,
                                            input logic [6:0] funct7);
        div_dec_t d;
        d = '0;
        if (opcode == INST_TYPE_R_M && funct7 == FUNCT7_MULDIV) begin
            case (funct3)
                FUNCT3_DIV:  d = '{is_div: 1'b1, is_signed: 1'b1, is_rem: 1'b0};
                FUNCT3_DIVU: d = '{is_div: 1'b1, is_signed: 1'b0, is_rem: 1'b0};
                FUNCT3_REM:  d = '{is_div: 1'b1, is_signed: 1'b1, is_rem: 1'b1};
                FUNCT3_REMU: d = '{is_div: 1'b1, is_signed: 1'b0, is_rem: 1'b1};
                default:     d = '0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/exe_div_if.sv
// ID/EXE-side request and writeback-side result signals of the divide unit.
interface exe_div_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0]  inst_in;
    logic [DATA_WIDTH-1:0]  op1_in;
    logic [DATA_WIDTH-1:0]  op2_in;
    logic [RADDR_WIDTH-1:0] reg_waddr_in;
    logic                   reg_we_in;
    logic                   jump_flush_in;
    logic                   hold_in;
    logic                   stall_req_out;
    logic                   result_valid_out;
    logic [DATA_WIDTH-1:0]  result_out;
    logic [RADDR_WIDTH-1:0] reg_waddr_out;
    logic                   reg_we_out;

    modport master (
        output inst_in, op1_in, op2_in, reg_waddr_in, reg_we_in, jump_flush_in, hold_in,
        input  stall_req_out, result_valid_out, result_out, reg_waddr_out, reg_we_out
    );

    modport slave (
        input  inst_in, op1_in, op2_in, reg_waddr_in, reg_we_in, jump_flush_in, hold_in,
        output stall_req_out, result_valid_out, result_out, reg_waddr_out, reg_we_out
    );
endinterface

// File: rtl/exe_div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, start/done
// handshake, abortable. done_out flags the final step; quo/rem show its result.
module div_core #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic [DATA_WIDTH-1:0] dividend_in,
    input  logic [DATA_WIDTH-1:0] divisor_in,
    output logic                  done_out,
    output logic [DATA_WIDTH-1:0] quo_out,
    output logic [DATA_WIDTH-1:0] rem_out
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DATA_WIDTH - 1);

    logic                  busy_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [DATA_WIDTH+1:0] trial;
    logic                  ge;
    logic [DATA_WIDTH-1:0] rem_nxt, quo_nxt;
    logic                  unused_trial;

    // Two guard bits: the shifted partial remainder can reach 2*divisor-1.
    assign trial        = {1'b0, rem_q, quo_q[DATA_WIDTH-1]} - {2'b00, dvs_q};
    assign ge           = ~trial[DATA_WIDTH+1];
    assign unused_trial = trial[DATA_WIDTH];
    // On a failed trial the shifted remainder is below the divisor, so its MSB is 0.
    assign rem_nxt      = ge ? trial[DATA_WIDTH-1:0] : {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]};
    assign quo_nxt      = {quo_q[DATA_WIDTH-2:0], ge};

    assign done_out = busy_q && (cnt_q == CNT_MAX);
    assign quo_out  = quo_nxt;
    assign rem_out  = rem_nxt;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else if (abort_in) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_in) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= dividend_in;
            dvs_q  <= divisor_in;
        end else if (busy_q) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (done_out)
                busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/exe_div.sv
// EXE-stage RV32M divide unit: decode, special cases, sign handling, flush and
// stall request around the iterative div_core.
module exe_div
    import exe_div_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int CNT_WIDTH   = 5
) (
    input  logic     clk_in,
    input  logic     reset_in,
    exe_div_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{DIV_ALL_ONES}};
    localparam logic [DATA_WIDTH-1:0] INT_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    div_state_e             state_q, state_d;
    div_dec_t               dec;
    logic                   sign1, sign2, div_zero, overflow, special;
    logic                   take, core_start, core_done, stall, valid;
    logic [DATA_WIDTH-1:0]  abs1, abs2, spec_res;
    logic [DATA_WIDTH-1:0]  core_quo, core_rem, fix_quo, fix_rem, final_res;
    logic [DATA_WIDTH-1:0]  res_q;
    logic [RADDR_WIDTH-1:0] waddr_q;
    logic                   we_q, quo_neg_q, rem_neg_q, is_rem_q;
    logic                   unused_inst;

    assign dec         = decode_div(bus.inst_in[6:0], bus.inst_in[14:12], bus.inst_in[31:25]);
    assign unused_inst = ^{bus.inst_in[24:15], bus.inst_in[11:7]};

    // Sign bits only matter for the signed ops; the core always sees magnitudes.
    assign sign1 = dec.is_signed & bus.op1_in[DATA_WIDTH-1];
    assign sign2 = dec.is_signed & bus.op2_in[DATA_WIDTH-1];
    assign abs1  = sign1 ? -bus.op1_in : bus.op1_in;
    assign abs2  = sign2 ? -bus.op2_in : bus.op2_in;

    assign div_zero = (bus.op2_in == '0);
    assign overflow = dec.is_signed && (bus.op1_in == INT_MIN) && (bus.op2_in == ALL_ONES);
    assign special  = div_zero || overflow;
    assign spec_res = div_zero ? (dec.is_rem ? bus.op1_in : ALL_ONES)
                               : (dec.is_rem ? '0 : INT_MIN);

    assign take       = (state_q == DIV_IDLE) && dec.is_div && !bus.jump_flush_in;
    assign core_start = take && !special;

    div_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_core (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .start_in    (core_start),
        .abort_in    (bus.jump_flush_in),
        .dividend_in (abs1),
        .divisor_in  (abs2),
        .done_out    (core_done),
        .quo_out     (core_quo),
        .rem_out     (core_rem)
    );

    assign fix_quo   = quo_neg_q ? -core_quo : core_quo;
    assign fix_rem   = rem_neg_q ? -core_rem : core_rem;
    assign final_res = is_rem_q ? fix_rem : fix_quo;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in)
            state_q <= DIV_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (take) begin
                    stall   = 1'b1;
                    state_d = special ? DIV_DONE : DIV_CALC;
                end
            end
            DIV_CALC: begin
                stall = 1'b1;
                if (core_done)
                    state_d = DIV_DONE;
            end
            DIV_DONE: begin
                if (!bus.hold_in)
                    state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
        // A flush wins over everything, including a downstream hold.
        if (bus.jump_flush_in)
            state_d = DIV_IDLE;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            res_q     <= '0;
            waddr_q   <= '0;
            we_q      <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            is_rem_q  <= 1'b0;
        end else begin
            if (take) begin
                quo_neg_q <= sign1 ^ sign2;
                rem_neg_q <= sign1;
                is_rem_q  <= dec.is_rem;
                waddr_q   <= bus.reg_waddr_in;
                we_q      <= bus.reg_we_in;
                if (special)
                    res_q <= spec_res;
            end
            if (state_q == DIV_CALC && core_done && !bus.jump_flush_in)
                res_q <= final_res;
        end
    end

    // Stall is combinational from IDLE, so mask it while reset is asserted.
    assign valid                = (state_q == DIV_DONE);
    assign bus.stall_req_out    = reset_in && stall;
    assign bus.result_valid_out = valid;
    assign bus.result_out       = valid ? res_q : '0;
    assign bus.reg_waddr_out    = valid ? waddr_q : '0;
    assign bus.reg_we_out       = valid && we_q;

endmodule

// File: tb/tb_exe_div.sv
// Self-checking bench for exe_div: directed vectors, randomized divides against
// a plain-arithmetic RV32M model, flush, reset, back-to-back and hold scenarios.
module tb_exe_div;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic clk_in   = 1'b0;
    logic reset_in = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    exe_div_if #(.DATA_WIDTH(32), .RADDR_WIDTH(5)) bus ();

    exe_div #(.DATA_WIDTH(32), .RADDR_WIDTH(5), .CNT_WIDTH(5)) dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, rd, opc};
    endfunction

    // RISC-V M-extension semantics written directly from the ISA rules.
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == MINV && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : MINV;
        case (f3)
            3'b100:  return 32'(sa / sb);
            3'b101:  return a / b;
            3'b110:  return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 0 || (!f3[0] && a == MINV && b == 32'hFFFF_FFFF)) return 2;
        return 34;
    endfunction

    // Present one divide (called just after a rising edge with the unit idle) and
    // collect what the unit reports; returns just after the edge that ends DONE.
    task automatic run_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic we,
                           output logic got, output logic [31:0] res, output logic [4:0] wa,
                           output logic wev, output int lat, output int stalls, output int dcyc);
        bus.inst_in      = mk_inst(7'b0000001, f3, rd, 7'b0110011);
        bus.op1_in       = a;
        bus.op2_in       = b;
        bus.reg_waddr_in = rd;
        bus.reg_we_in    = we;
        got = 1'b0; res = '0; wa = '0; wev = 1'b0; lat = 0; stalls = 0; dcyc = 0;
        while (!got && lat < 100) begin
            @(negedge clk_in);
            lat++;
            if (bus.stall_req_out) stalls++;
            if (bus.result_valid_out) begin
                got  = 1'b1;
                res  = bus.result_out;
                wa   = bus.reg_waddr_out;
                wev  = bus.reg_we_out;
                dcyc = cyc;
            end
            @(posedge clk_in); #1;
        end
    endtask

    task automatic idle_cycle();
        bus.inst_in = NOP;
        @(posedge clk_in); #1;
    endtask

    task automatic test_reset();
        bus.inst_in = mk_inst(7'b0000001, 3'b101, 5'd1, 7'b0110011);
        bus.op1_in = 32'd100; bus.op2_in = 32'd7; bus.reg_waddr_in = 5'd1; bus.reg_we_in = 1'b1;
        bus.jump_flush_in = 1'b0; bus.hold_in = 1'b0;
        #3;
        n_checks++;
        if ({bus.stall_req_out, bus.result_valid_out, bus.reg_we_out} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000", {bus.stall_req_out, bus.result_valid_out, bus.reg_we_out});
        end
        n_checks++;
        if ({bus.result_out, bus.reg_waddr_out} !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", {bus.result_out, bus.reg_waddr_out});
        end
        bus.inst_in = NOP;
        @(negedge clk_in); reset_in = 1'b1;
        @(posedge clk_in); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [10] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] as  [10] = '{32'd100, 32'd100, -32'sd7, -32'sd7, 32'd7, 32'd7, 32'd5, 32'd5, MINV, MINV};
        logic [31:0] bs  [10] = '{32'd7, 32'd7, 32'd2, 32'd2, -32'sd2, -32'sd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1,
                                  32'hFFFF_FFFF, 32'd5, MINV, 32'd0};
        int          lats[10] = '{34, 34, 34, 34, 34, 34, 2, 2, 2, 2};
        logic got, wev; logic [31:0] res; logic [4:0] wa; int lat, st, dc;
        for (int i = 0; i < 10; i++) begin
            run_div(f3s[i], as[i], bs[i], 5'(i + 1), 1'b1, got, res, wa, wev, lat, st, dc);
            idle_cycle();
            n_checks++;
            if (!got || res !== exp[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got %h valid %b expected %h", i, res, got, exp[i]);
            end
            n_checks++;
            if (lat !== lats[i] || st !== lats[i] - 1) begin
                n_fail++;
                $display("FAIL directed_timing[%0d]: got latency %0d stalls %0d expected %0d / %0d",
                         i, lat, st, lats[i], lats[i] - 1);
            end
            n_checks++;
            if (wa !== 5'(i + 1) || wev !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_wb[%0d]: got rd %0d we %b expected %0d / 1", i, wa, wev, i + 1);
            end
        end
    endtask

    task automatic test_random();
        logic got, wev, we; logic [31:0] res, a, b, e; logic [4:0] wa, rd; logic [2:0] f3; int lat, st, dc, el;
        for (int i = 0; i < 24; i++) begin
            f3 = 3'(4 + $urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = MINV; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 40); end
                3: b = -32'($urandom_range(1, 300));
                4: b = $urandom_range(1, 16);
                default: ;
            endcase
            rd = 5'($urandom);
            we = 1'($urandom);
            e  = ref_div(f3, a, b);
            el = ref_lat(f3, a, b);
            run_div(f3, a, b, rd, we, got, res, wa, wev, lat, st, dc);
            idle_cycle();
            n_checks++;
            if (!got || res !== e || wa !== rd || wev !== we || lat !== el || st !== el - 1) begin
                n_fail++;
                $display("FAIL random[%0d] f3=%b a=%h b=%h: got %h rd %0d we %b lat %0d st %0d expected %h rd %0d we %b lat %0d",
                         i, f3, a, b, res, wa, wev, lat, st, e, rd, we, el);
            end
        end
    endtask

    task automatic test_flush();
        int seen;
        logic got, wev; logic [31:0] res; logic [4:0] wa; int lat, st, dc;
        bus.inst_in = mk_inst(7'b0000001, 3'b101, 5'd4, 7'b0110011);
        bus.op1_in = 32'd1000; bus.op2_in = 32'd3; bus.reg_waddr_in = 5'd4; bus.reg_we_in = 1'b1;
        repeat (10) begin @(posedge clk_in); #1; end
        n_checks++;
        if (bus.stall_req_out !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre_stall: got %b expected 1", bus.stall_req_out);
        end
        bus.jump_flush_in = 1'b1;
        @(posedge clk_in); #1;
        bus.jump_flush_in = 1'b0;
        bus.inst_in = NOP;
        @(negedge clk_in);
        n_checks++;
        if ({bus.stall_req_out, bus.result_valid_out, bus.reg_we_out} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_next: got %b expected 000", {bus.stall_req_out, bus.result_valid_out, bus.reg_we_out});
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk_in);
            if (bus.result_valid_out) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL flush_no_valid: got %0d valid cycles expected 0", seen);
        end
        @(posedge clk_in); #1;
        run_div(3'b101, 32'd1000, 32'd3, 5'd6, 1'b1, got, res, wa, wev, lat, st, dc);
        idle_cycle();
        n_checks++;
        if (!got || res !== 32'd333 || lat !== 34) begin
            n_fail++;
            $display("FAIL flush_recover: got %h lat %0d expected 0000014d lat 34", res, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic got, wev; logic [31:0] res; logic [4:0] wa; int lat, st, dc;
        bus.inst_in = mk_inst(7'b0000001, 3'b110, 5'd8, 7'b0110011);
        bus.op1_in = -32'sd1000; bus.op2_in = 32'd7; bus.reg_waddr_in = 5'd8; bus.reg_we_in = 1'b1;
        repeat (20) begin @(posedge clk_in); #1; end
        #2 reset_in = 1'b0;
        #1;
        n_checks++;
        if ({bus.stall_req_out, bus.result_valid_out, bus.result_out, bus.reg_waddr_out, bus.reg_we_out} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected 0",
                     {bus.stall_req_out, bus.result_valid_out, bus.result_out, bus.reg_waddr_out, bus.reg_we_out});
        end
        bus.inst_in = NOP;
        @(negedge clk_in); reset_in = 1'b1;
        @(posedge clk_in); #1;
        run_div(3'b110, -32'sd1000, 32'd7, 5'd8, 1'b1, got, res, wa, wev, lat, st, dc);
        idle_cycle();
        n_checks++;
        if (!got || res !== 32'hFFFF_FFFA || wa !== 5'd8) begin
            n_fail++;
            $display("FAIL reset_recover: got %h rd %0d expected fffffffa rd 8", res, wa);
        end
    endtask

    task automatic test_back_to_back();
        logic g1, g2, w1, w2; logic [31:0] r1, r2; logic [4:0] a1, a2; int l1, l2, s1, s2, d1, d2;
        run_div(3'b101, 32'd50, 32'd5, 5'd3, 1'b1, g1, r1, a1, w1, l1, s1, d1);
        run_div(3'b101, 32'd9, 32'd4, 5'd9, 1'b1, g2, r2, a2, w2, l2, s2, d2);
        idle_cycle();
        n_checks++;
        if (!g1 || r1 !== 32'd10 || a1 !== 5'd3) begin
            n_fail++;
            $display("FAIL b2b_first: got %h rd %0d expected 0000000a rd 3", r1, a1);
        end
        n_checks++;
        if (!g2 || r2 !== 32'd2 || a2 !== 5'd9) begin
            n_fail++;
            $display("FAIL b2b_second: got %h rd %0d expected 00000002 rd 9", r2, a2);
        end
        n_checks++;
        if (d2 - d1 !== 34) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles expected 34", d2 - d1);
        end
    endtask

    task automatic test_hold();
        int n;
        bus.inst_in = mk_inst(7'b0000001, 3'b101, 5'd12, 7'b0110011);
        bus.op1_in = 32'd77; bus.op2_in = 32'd7; bus.reg_waddr_in = 5'd12; bus.reg_we_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!bus.result_valid_out && n < 100);
        bus.hold_in = 1'b1;
        n_checks++;
        if (!bus.result_valid_out || bus.result_out !== 32'd11 || bus.reg_waddr_out !== 5'd12) begin
            n_fail++;
            $display("FAIL hold_first: got valid %b %h rd %0d expected 1 0000000b rd 12",
                     bus.result_valid_out, bus.result_out, bus.reg_waddr_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_in); #1;
            if (i == 2) begin
                bus.hold_in = 1'b0;
                bus.inst_in = NOP;
            end
            @(negedge clk_in);
            n_checks++;
            if (!bus.result_valid_out || bus.result_out !== 32'd11 || bus.reg_waddr_out !== 5'd12 || bus.stall_req_out) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: got valid %b %h rd %0d stall %b expected 1 0000000b rd 12 stall 0",
                         i, bus.result_valid_out, bus.result_out, bus.reg_waddr_out, bus.stall_req_out);
            end
        end
        @(posedge clk_in); #1;
        @(negedge clk_in);
        n_checks++;
        if (bus.result_valid_out !== 1'b0 || bus.stall_req_out !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: got valid %b stall %b expected 0 0", bus.result_valid_out, bus.stall_req_out);
        end
        @(posedge clk_in); #1;
    endtask

    task automatic test_non_div();
        logic [31:0] insts [3];
        insts[0] = mk_inst(7'b0000001, 3'b000, 5'd5, 7'b0110011);
        insts[1] = mk_inst(7'b0000000, 3'b100, 5'd5, 7'b0110011);
        insts[2] = mk_inst(7'b0000001, 3'b100, 5'd5, 7'b0010011);
        for (int i = 0; i < 3; i++) begin
            bus.inst_in = insts[i];
            bus.op1_in = $urandom; bus.op2_in = $urandom; bus.reg_waddr_in = 5'd5; bus.reg_we_in = 1'b1;
            repeat (3) begin
                @(negedge clk_in);
                n_checks++;
                if ({bus.stall_req_out, bus.result_valid_out, bus.result_out, bus.reg_waddr_out, bus.reg_we_out} !== 40'h0) begin
                    n_fail++;
                    $display("FAIL non_div[%0d]: got %h expected 0", i,
                             {bus.stall_req_out, bus.result_valid_out, bus.result_out, bus.reg_waddr_out, bus.reg_we_out});
                end
                @(posedge clk_in); #1;
            end
        end
        bus.inst_in = NOP;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_hold();
        test_non_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
